// File: rtl/code_lock_pkg.sv
// Shared encodings for the keypad code lock: mode values, error causes and a
// one-hot-low to index helper.
package code_lock_pkg;

    localparam logic [2:0] MODE_UNLOCKED = 3'd0;
    localparam logic [2:0] MODE_SET      = 3'd1;
    localparam logic [2:0] MODE_CONFIRM  = 3'd2;
    localparam logic [2:0] MODE_LOCKED   = 3'd3;
    localparam logic [2:0] MODE_LOCKOUT  = 3'd4;

    localparam logic [2:0] ERR_NONE             = 3'd0;
    localparam logic [2:0] ERR_MULTI_KEY        = 3'd1;
    localparam logic [2:0] ERR_CONFIRM_MISMATCH = 3'd2;
    localparam logic [2:0] ERR_WRONG_CODE       = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT          = 3'd4;
    localparam logic [2:0] ERR_LOCKOUT          = 3'd5;

    // Index of the lowest set bit; callers only pass one-hot vectors.
    function automatic logic [3:0] low_index(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--)
            if (v[i]) r = 4'(i);
        return r;
    endfunction

endpackage

// File: rtl/code_lock_ctrl_key_decoder.sv
// Keypad front end: turns active-low key lines into single-press and
// multi-key events, with release tracking that can be suppressed.
module key_decoder
    import code_lock_pkg::*;
#(
    parameter int NUM_KEYS = 4,
    parameter int DIGIT_W  = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key,
    input  logic                ignore,
    output logic                press,
    output logic                multi,
    output logic [DIGIT_W-1:0]  index
);

    logic [NUM_KEYS-1:0] low;
    logic                idle, one_low, many_low;
    logic                prev_idle, prev_multi, armed;

    assign low      = ~key;
    assign idle     = (low == '0);
    assign one_low  = ($countones(low) == 1);
    assign many_low = ($countones(low) > 1);

    // armed drops while ignored, so a key held across that window never counts.
    assign press = armed && prev_idle && one_low && !ignore;
    assign multi = armed && many_low && !prev_multi && !ignore;
    assign index = DIGIT_W'(low_index(16'(low)));

    always_ff @(posedge clock) begin
        if (!reset) begin
            prev_idle  <= 1'b0;
            prev_multi <= 1'b0;
            armed      <= 1'b0;
        end else begin
            prev_idle  <= idle;
            prev_multi <= many_low;
            armed      <= !ignore && (armed || idle);
        end
    end

endmodule

// File: rtl/code_lock_ctrl.sv
// Keypad code lock: set and confirm a code, lock, unlock with the code, and
// lock out the keypad after repeated failed attempts.
module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int NUM_KEYS       = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int LOCKOUT_CYCLES = 5000,
    localparam int DIGIT_W       = $clog2(NUM_KEYS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key,
    output logic                lock,
    output logic [2:0]          mode,
    output logic [3:0]          digit_count,
    output logic                digit_valid,
    output logic [DIGIT_W-1:0]  digit_value,
    output logic                error,
    output logic [2:0]          err_code,
    output logic [3:0]          fail_count
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] code;
    logic [IW-1:0]      cnt;
    logic [TW-1:0]      idle_tmr;
    logic [LW-1:0]      lock_tmr;
    logic               bad;
    logic               press, multi;
    logic [DIGIT_W-1:0] idx;
    logic               hit, last_digit, timeout, final_fail;

    key_decoder #(.NUM_KEYS(NUM_KEYS), .DIGIT_W(DIGIT_W)) u_dec (
        .clock  (clock),
        .reset  (reset),
        .key    (key),
        .ignore (mode == MODE_LOCKOUT),
        .press  (press),
        .multi  (multi),
        .index  (idx)
    );

    assign lock        = (mode == MODE_LOCKED) || (mode == MODE_LOCKOUT);
    assign digit_count = 4'(cnt);
    assign hit         = (code[cnt] == idx);
    assign last_digit  = (cnt == IW'(NUM_DIGITS - 1));
    assign timeout     = (cnt != '0) && (idle_tmr == TW'(TIMEOUT_CYCLES));
    assign final_fail  = (fail_count == 4'(MAX_ATTEMPTS - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            mode        <= MODE_UNLOCKED;
            code        <= '0;
            cnt         <= '0;
            idle_tmr    <= '0;
            lock_tmr    <= '0;
            bad         <= 1'b0;
            fail_count  <= '0;
            digit_valid <= 1'b0;
            digit_value <= '0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            digit_valid <= 1'b0;
            error       <= 1'b0;
            if (mode == MODE_LOCKOUT) begin
                if (lock_tmr == LW'(LOCKOUT_CYCLES - 1)) begin
                    mode       <= MODE_LOCKED;
                    fail_count <= '0;
                    lock_tmr   <= '0;
                end else begin
                    lock_tmr <= lock_tmr + LW'(1);
                end
            end else if (timeout) begin
                error    <= 1'b1;
                err_code <= ERR_TIMEOUT;
                cnt      <= '0;
                bad      <= 1'b0;
                idle_tmr <= '0;
                if (mode != MODE_LOCKED) mode <= MODE_UNLOCKED;
            end else if (multi) begin
                // A chorded press is a wrong digit: it aborts entry and costs an attempt.
                error    <= 1'b1;
                err_code <= ERR_MULTI_KEY;
                cnt      <= '0;
                bad      <= 1'b0;
                idle_tmr <= '0;
                if (mode == MODE_LOCKED) begin
                    fail_count <= fail_count + 4'd1;
                    if (final_fail) begin
                        mode     <= MODE_LOCKOUT;
                        err_code <= ERR_LOCKOUT;
                        lock_tmr <= '0;
                    end
                end else if (mode != MODE_UNLOCKED) begin
                    mode <= MODE_UNLOCKED;
                    code <= '0;
                end
            end else if (press) begin
                digit_valid <= 1'b1;
                digit_value <= idx;
                idle_tmr    <= '0;
                case (mode)
                    MODE_UNLOCKED, MODE_SET: begin
                        code[cnt] <= idx;
                        cnt       <= last_digit ? '0 : cnt + IW'(1);
                        mode      <= last_digit ? MODE_CONFIRM : MODE_SET;
                    end
                    MODE_CONFIRM: begin
                        if (!hit) begin
                            error    <= 1'b1;
                            err_code <= ERR_CONFIRM_MISMATCH;
                            code     <= '0;
                            cnt      <= '0;
                            mode     <= MODE_UNLOCKED;
                        end else if (last_digit) begin
                            cnt  <= '0;
                            mode <= MODE_LOCKED;
                        end else begin
                            cnt <= cnt + IW'(1);
                        end
                    end
                    MODE_LOCKED: begin
                        // Mismatches are remembered and only judged once the full code is in.
                        if (!last_digit) begin
                            cnt <= cnt + IW'(1);
                            bad <= bad || !hit;
                        end else begin
                            cnt <= '0;
                            bad <= 1'b0;
                            if (!bad && hit) begin
                                mode       <= MODE_UNLOCKED;
                                fail_count <= '0;
                            end else begin
                                error      <= 1'b1;
                                fail_count <= fail_count + 4'd1;
                                if (final_fail) begin
                                    mode     <= MODE_LOCKOUT;
                                    err_code <= ERR_LOCKOUT;
                                    lock_tmr <= '0;
                                end else begin
                                    err_code <= ERR_WRONG_CODE;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end else if (cnt != '0) begin
                idle_tmr <= idle_tmr + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Bench for code_lock_ctrl: directed scenarios then random key traffic, every
// cycle compared against a queue-based model of the lock's rules.
module tb_code_lock_ctrl;
    import code_lock_pkg::*;

    localparam int ND = 4, NK = 4, MAXA = 3, TO = 20, LO = 50;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] key = 4'hF;
    logic       lock, digit_valid, error;
    logic [2:0] mode, err_code;
    logic [3:0] digit_count, fail_count;
    logic [1:0] digit_value;

    code_lock_ctrl #(.NUM_DIGITS(ND), .NUM_KEYS(NK), .MAX_ATTEMPTS(MAXA),
                     .TIMEOUT_CYCLES(TO), .LOCKOUT_CYCLES(LO)) dut (
        .clock(clock), .reset(reset), .key(key), .lock(lock), .mode(mode),
        .digit_count(digit_count), .digit_valid(digit_valid), .digit_value(digit_value),
        .error(error), .err_code(err_code), .fail_count(fail_count)
    );

    always #5 clock = ~clock;

    int vectors = 0, miscompares = 0, dv_seen = 0;

    // Model state: entered digits and stored code as queues
    int m_mode, m_fail, m_idle, m_left, m_dval, m_errc;
    bit m_dv, m_err, m_prev_idle, m_prev_multi, m_armed;
    int ent_q[$], code_q[$];

    task automatic raise(input int c);
        m_err = 1'b1;
        m_errc = c;
    endtask

    task automatic count_failure();
        m_fail++;
        m_err = 1'b1;
        if (m_fail == MAXA) begin
            m_mode = MODE_LOCKOUT;
            m_left = LO;
            m_errc = ERR_LOCKOUT;
        end
    endtask

    function automatic bit same_code();
        for (int i = 0; i < ND; i++)
            if (ent_q[i] != code_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input logic [3:0] k, input logic r);
        int  nlow, d;
        bit  idle_now, one, many, in_lo, pr, mv;
        if (!r) begin
            m_mode = MODE_UNLOCKED; m_fail = 0; m_idle = 0; m_left = 0;
            m_dval = 0; m_errc = ERR_NONE; m_dv = 0; m_err = 0;
            m_prev_idle = 0; m_prev_multi = 0; m_armed = 0;
            ent_q.delete(); code_q.delete();
            return;
        end
        nlow = $countones(~k);
        idle_now = (nlow == 0); one = (nlow == 1); many = (nlow >= 2);
        d = 0;
        for (int i = NK - 1; i >= 0; i--) if (!k[i]) d = i;
        in_lo = (m_mode == MODE_LOCKOUT);
        pr = !in_lo && m_armed && m_prev_idle && one;
        mv = !in_lo && m_armed && many && !m_prev_multi;
        m_armed = !in_lo && (m_armed || idle_now);
        m_prev_idle = idle_now;
        m_prev_multi = many;
        m_dv = 0; m_err = 0;
        if (in_lo) begin
            m_left--;
            if (m_left == 0) begin m_mode = MODE_LOCKED; m_fail = 0; end
        end else if (ent_q.size() > 0 && m_idle == TO) begin
            raise(ERR_TIMEOUT); ent_q.delete(); m_idle = 0;
            if (m_mode != MODE_LOCKED) m_mode = MODE_UNLOCKED;
        end else if (mv) begin
            raise(ERR_MULTI_KEY); ent_q.delete(); m_idle = 0;
            if (m_mode == MODE_LOCKED) count_failure();
            else m_mode = MODE_UNLOCKED;
        end else if (pr) begin
            m_dv = 1; m_dval = d; m_idle = 0;
            if (m_mode == MODE_UNLOCKED || m_mode == MODE_SET) begin
                ent_q.push_back(d); m_mode = MODE_SET;
                if (ent_q.size() == ND) begin code_q = ent_q; ent_q.delete(); m_mode = MODE_CONFIRM; end
            end else if (m_mode == MODE_CONFIRM) begin
                if (d != code_q[ent_q.size()]) begin
                    raise(ERR_CONFIRM_MISMATCH); ent_q.delete(); code_q.delete(); m_mode = MODE_UNLOCKED;
                end else begin
                    ent_q.push_back(d);
                    if (ent_q.size() == ND) begin ent_q.delete(); m_mode = MODE_LOCKED; end
                end
            end else if (m_mode == MODE_LOCKED) begin
                ent_q.push_back(d);
                if (ent_q.size() == ND) begin
                    if (same_code()) begin m_mode = MODE_UNLOCKED; m_fail = 0; end
                    else begin raise(ERR_WRONG_CODE); count_failure(); end
                    ent_q.delete();
                end
            end
        end else if (ent_q.size() > 0) begin
            m_idle++;
        end
    endtask

    task automatic check_all();
        logic [18:0] obs, exp;
        logic        lk;
        lk  = (m_mode == MODE_LOCKED) || (m_mode == MODE_LOCKOUT);
        obs = {lock, mode, digit_count, digit_valid, digit_value, error, err_code, fail_count};
        exp = {lk, 3'(m_mode), 4'(ent_q.size()), m_dv, 2'(m_dval), m_err, 3'(m_errc), 4'(m_fail)};
        if (digit_valid === 1'b1) dv_seen++;
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL cycle t=%0t obs{lock,mode,cnt,dv,dval,err,code,fail}=%h exp=%h", $time, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic [3:0] k, input logic r = 1'b1);
        @(negedge clock);
        key = k;
        reset = r;
        @(posedge clock);
        model_step(k, r);
        #1;
        check_all();
    endtask

    task automatic press(input int d);
        logic [3:0] v;
        v = 4'hF;
        v[d] = 1'b0;
        cycle(v);
        cycle(4'hF);
    endtask

    task automatic press_seq(input int a, input int b, input int c, input int e);
        press(a); press(b); press(c); press(e);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, lo_cnt, act, n, gap;
        int rc[ND];
        logic [3:0] mk;

        cycle(4'hF, 1'b0); cycle(4'hF, 1'b0);
        chk("rst_mode", mode, MODE_UNLOCKED);
        chk("rst_lock", lock, 0);
        chk("rst_fail", fail_count, 0);
        cycle(4'hF); cycle(4'hF);

        // set, confirm, lock
        base = dv_seen;
        press(0);
        chk("set_mode", mode, MODE_SET);
        press(1); press(2); press(3);
        chk("confirm_mode", mode, MODE_CONFIRM);
        chk("confirm_cnt", digit_count, 0);
        press_seq(0, 1, 2, 3);
        chk("locked_mode", mode, MODE_LOCKED);
        chk("locked_lock", lock, 1);
        chk("dv_pulses", dv_seen - base, 8);

        // unlock
        press_seq(0, 1, 2, 3);
        chk("unlock_mode", mode, MODE_UNLOCKED);
        chk("unlock_lock", lock, 0);
        chk("unlock_fail", fail_count, 0);

        // relock, then three wrong codes
        press_seq(0, 1, 2, 3); press_seq(0, 1, 2, 3);
        press_seq(3, 3, 3, 3);
        chk("wrong1_fail", fail_count, 1);
        chk("wrong1_code", err_code, ERR_WRONG_CODE);
        press_seq(3, 3, 3, 3);
        chk("wrong2_fail", fail_count, 2);
        press(3); press(3); press(3);
        cycle(4'b0111);
        chk("lockout_mode", mode, MODE_LOCKOUT);
        chk("lockout_code", err_code, ERR_LOCKOUT);
        lo_cnt = 1;
        while (mode == MODE_LOCKOUT && lo_cnt < 100) begin
            cycle(4'($urandom));
            if (mode == MODE_LOCKOUT) lo_cnt++;
        end
        chk("lockout_len", lo_cnt, LO);
        chk("post_lockout_mode", mode, MODE_LOCKED);
        chk("post_lockout_fail", fail_count, 0);
        cycle(4'hF); cycle(4'hF);

        // chorded keys while locked
        cycle(4'b1100);
        chk("multi_err", error, 1);
        chk("multi_code", err_code, ERR_MULTI_KEY);
        chk("multi_fail", fail_count, 1);
        cycle(4'hF); cycle(4'hF);

        // reset on the third digit of an unlock attempt
        press(0); press(1);
        cycle(4'b1011, 1'b0);
        chk("mrst_mode", mode, MODE_UNLOCKED);
        chk("mrst_lock", lock, 0);
        chk("mrst_cnt", digit_count, 0);
        chk("mrst_fail", fail_count, 0);
        chk("mrst_errcode", err_code, ERR_NONE);
        chk("mrst_dv", digit_valid, 0);
        chk("mrst_dval", digit_value, 0);
        cycle(4'hF); cycle(4'hF);
        press(2);
        chk("mrst_new_set", mode, MODE_SET);
        for (int i = 0; i < 21; i++) cycle(4'hF);
        chk("set_timeout_mode", mode, MODE_UNLOCKED);

        // confirm mismatch
        press_seq(0, 1, 2, 3);
        press(1);
        chk("mismatch_code", err_code, ERR_CONFIRM_MISMATCH);
        chk("mismatch_mode", mode, MODE_UNLOCKED);

        // timeout in CONFIRM with a random code
        for (int i = 0; i < ND; i++) rc[i] = $urandom_range(0, NK - 1);
        for (int i = 0; i < ND; i++) press(rc[i]);
        press(rc[0]);
        chk("to_cnt", digit_count, 1);
        for (int i = 0; i < 19; i++) cycle(4'hF);
        chk("to_not_yet", error, 0);
        chk("to_still_confirm", mode, MODE_CONFIRM);
        cycle(4'hF);
        chk("to_err", error, 1);
        chk("to_code", err_code, ERR_TIMEOUT);
        chk("to_mode", mode, MODE_UNLOCKED);

        // random traffic
        for (int it = 0; it < 300; it++) begin
            act = $urandom_range(0, 99);
            if (act < 45) begin
                press($urandom_range(0, NK - 1));
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) cycle(4'hF);
            end else if (act < 75) begin
                n = code_q.size();
                for (int i = 0; i < ND; i++)
                    rc[i] = (n == ND && $urandom_range(0, 3) != 0) ? code_q[i] : $urandom_range(0, NK - 1);
                for (int i = 0; i < ND; i++) press(rc[i]);
            end else if (act < 85) begin
                do mk = 4'($urandom); while ($countones(~mk) < 2);
                cycle(mk);
                cycle(4'hF);
            end else if (act < 96) begin
                gap = $urandom_range(15, 25);
                for (int g = 0; g < gap; g++) cycle(4'hF);
            end else begin
                cycle(4'hF, 1'b0);
                cycle(4'hF);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/code_lock_ctrl.md
CODE_LOCK_CTRL -- requirements
Module: code_lock_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: code length in digits, legal range 1..8.
REQ-002 SHALL have parameter NUM_KEYS, default 4: keypad size, legal range 2..16; DIGIT_W = clog2(NUM_KEYS).
REQ-003 SHALL have parameter MAX_ATTEMPTS, default 3: consecutive failed unlock attempts that trigger lockout, legal range 1..15.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000: allowed idle clocks between accepted digits.
REQ-005 SHALL have parameter LOCKOUT_CYCLES, default 5000: lockout duration in clocks.
REQ-006 SHALL have port clock, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1: one clock; reset is synchronous and active-low.
REQ-008 SHALL have port key, input, NUM_KEYS: active-low keypad lines; all-ones means released.
REQ-009 SHALL have port lock, output, 1: high in LOCKED and LOCKOUT.
REQ-010 SHALL have port mode, output, 3: current mode, encoded per the package.
REQ-011 SHALL have port digit_count, output, 4: digits accepted in the current entry.
REQ-012 SHALL have port digit_valid, output, 1: one-cycle pulse per accepted digit.
REQ-013 SHALL have port digit_value, output, DIGIT_W: index of the last accepted key.
REQ-014 SHALL have port error, output, 1: one-cycle pulse on any error.
REQ-015 SHALL have port err_code, output, 3: cause of the last error; held until the next error.
REQ-016 SHALL have port fail_count, output, 4: consecutive failed unlock attempts.

Function
REQ-017 SHALL implement modes UNLOCKED, SET, CONFIRM, LOCKED and LOCKOUT.
REQ-018 SHALL accept a press only on the clock where key is exactly one-low and key was all-ones on the previous clock.
REQ-019 SHALL, on an accepted press, update digit_valid, digit_value and digit_count at that same edge.
REQ-020 SHALL treat any sample with two or more keys low as err_code MULTI_KEY, counting the entry as a wrong digit.
REQ-021 SHALL move UNLOCKED -> SET on the first accepted digit, storing it in code slot 0.
REQ-022 SHALL store digits in SET; on digit NUM_DIGITS, clear digit_count and enter CONFIRM at that edge.
REQ-023 SHALL compare digits in CONFIRM; when all NUM_DIGITS match, enter LOCKED at the final-digit edge.
REQ-024 SHALL, on any CONFIRM mismatch, return to UNLOCKED immediately with err_code CONFIRM_MISMATCH, zeroing the stored code.
REQ-025 SHALL, in LOCKED, evaluate only after NUM_DIGITS digits: a match enters UNLOCKED and clears fail_count.
REQ-026 SHALL, on a LOCKED mismatch, raise err_code WRONG_CODE, increment fail_count, clear digit_count and stay LOCKED.
REQ-027 SHALL enter LOCKOUT when fail_count reaches MAX_ATTEMPTS; err_code is LOCKOUT.
REQ-028 SHALL ignore keys for LOCKOUT_CYCLES in LOCKOUT, then enter LOCKED with fail_count 0.
REQ-029 SHALL accept no press after LOCKOUT until all keys have been seen released.
REQ-030 SHALL restart the inter-digit timer on each accepted digit while digit_count is nonzero.
REQ-031 SHALL, on timer expiry, clear digit_count and raise err_code TIMEOUT.
REQ-032 SHALL, on timeout in SET or CONFIRM, return to UNLOCKED; in LOCKED, stay LOCKED with fail_count unchanged.
REQ-033 SHALL give an error in the same cycle as an accepted press priority over the press.

Reset
REQ-034 SHALL, while reset=0 at a clock edge, set mode UNLOCKED and lock 0.
REQ-035 SHALL, while reset=0 at a clock edge, zero the stored code, digit_count, fail_count, timers, digit_valid, digit_value, error and err_code.
REQ-036 SHALL treat a reset arriving mid-entry or mid-lockout identically to a reset at power-up.

Structure
REQ-037 SHALL take the mode encoding and err_code values (NONE, MULTI_KEY, CONFIRM_MISMATCH, WRONG_CODE, TIMEOUT, LOCKOUT) from the shared package code_lock_pkg.
REQ-038 SHALL use one sub-module, key_decoder, for release tracking, single-press edge detection, multi-key detection and one-hot to binary conversion.

Verification (NUM_DIGITS=4, NUM_KEYS=4, MAX_ATTEMPTS=3, TIMEOUT_CYCLES=20, LOCKOUT_CYCLES=50)
REQ-039 SHALL test set and lock: press 0,1,2,3 then 0,1,2,3 -> mode SET then CONFIRM then LOCKED, lock=1, 8 digit_valid pulses.
REQ-040 SHALL test unlock: while LOCKED enter 0,1,2,3 -> mode UNLOCKED, lock=0, fail_count=0.
REQ-041 SHALL test lockout: enter 3,3,3,3 three times -> fail_count 1,2 then LOCKOUT; keys ignored for 50 clocks; then LOCKED with fail_count 0.
REQ-042 SHALL test timeout: in CONFIRM, press one digit then idle 21 clocks -> error pulse, err_code TIMEOUT, mode UNLOCKED.
REQ-043 SHALL test multi-key: key=4'b1100 while LOCKED -> err_code MULTI_KEY, fail_count incremented.
REQ-044 SHALL test reset: assert reset=0 for one clock at the third digit of an unlock attempt -> mode UNLOCKED, all outputs zero, stored code cleared.
